divider_32bit: RTL and testbench

- Multi-cycle radix-2 restoring divider serving the RV32M divide group: funct3 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- It is the inverse companion of the single-cycle ALU multiply path. The ALU handles funct3 000 combinationally; the decode/control path routes funct3[2]=1 with Mul_ext_i=1 to this block and stalls the PC until Valid_o.
- Start/busy/valid handshake; one quotient bit per clock.

---
 rtl/divider_32bit.sv | 173 +++++++++++++++++
 tb/tb_divider_32bit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/divider_32bit.sv
// divider_32bit
//   Multi-cycle radix-2 restoring divider for the RV32M divide group
//   (DIV, DIVU, REM, REMU). One quotient bit is produced per clock.
//
//   Optional feature macro: DIV_EARLY_OUT_EN
//     When defined, operations whose dividend magnitude is below the divisor
//     magnitude finish in IDLE (quotient 0, remainder = dividend).
//     Results are identical either way; only latency changes.
//
// Ports:
//   clk_i     in   clock, rising edge
//   rst_ni    in   asynchronous active-low reset
//   Start_i   in   request, sampled only in IDLE
//   Funct_i   in   [1:0] funct3[1:0]: bit0=1 unsigned, bit1=1 remainder
//   rs1_i     in   [WIDTH-1:0] dividend
//   rs2_i     in   [WIDTH-1:0] divisor
//   Result_o  out  [WIDTH-1:0] quotient or remainder (registered, held)
//   Busy_o    out  high whenever the FSM is not in IDLE
//   Valid_o   out  one-cycle pulse, Result_o valid
module divider_32bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             Start_i,
  input  logic [1:0]       Funct_i,
  input  logic [WIDTH-1:0] rs1_i,
  input  logic [WIDTH-1:0] rs2_i,
  output logic [WIDTH-1:0] Result_o,
  output logic             Busy_o,
  output logic             Valid_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] rem_reg;     // partial remainder
  logic [WIDTH-1:0] dvd_reg;     // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dsr_reg;     // divisor magnitude
  logic             neg_q_reg;
  logic             neg_r_reg;
  logic             rem_sel_reg;
  logic [WIDTH-1:0] result_reg;
  logic             valid_reg;

  // ---------------- request decode (used in IDLE) ----------------
  logic             is_signed;
  logic             sign1;
  logic             sign2;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic             div_zero;
  logic             overflow;
  logic             early;
  logic [WIDTH-1:0] special_res;

  assign is_signed = ~Funct_i[0];
  assign sign1     = is_signed & rs1_i[WIDTH-1];
  assign sign2     = is_signed & rs2_i[WIDTH-1];
  // Negating the most negative value yields 2^(WIDTH-1) read as unsigned,
  // which the unsigned datapath handles without overflow.
  assign mag1      = sign1 ? (~rs1_i + 1'b1) : rs1_i;
  assign mag2      = sign2 ? (~rs2_i + 1'b1) : rs2_i;
  assign div_zero  = (rs2_i == '0);
  assign overflow  = is_signed && (rs1_i == {1'b1, {(WIDTH-1){1'b0}}})
                     && (rs2_i == '1);

`ifdef DIV_EARLY_OUT_EN
  assign early = ~div_zero && (mag1 < mag2);
`else
  assign early = 1'b0;
`endif

  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = Funct_i[1] ? rs1_i : '1;
    else if (overflow)
      special_res = Funct_i[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
    else
      special_res = Funct_i[1] ? rs1_i : '0;   // early-out: |rs1| < |rs2|
  end

  // ---------------- one restoring step (used in CALC) ----------------
  // The shifted remainder keeps WIDTH+1 bits so divisors with the MSB set
  // (unsigned operands, or magnitude 2^31) never lose the top bit.
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] dvd_step;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] final_res;

  assign shifted   = {rem_reg, dvd_reg[WIDTH-1]};
  assign diff      = shifted - {1'b0, dsr_reg};
  assign q_bit     = ~diff[WIDTH];
  assign rem_step  = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign dvd_step  = {dvd_reg[WIDTH-2:0], q_bit};
  assign quo_fix   = neg_q_reg ? (~dvd_step + 1'b1) : dvd_step;
  assign rem_fix   = neg_r_reg ? (~rem_step + 1'b1) : rem_step;
  assign final_res = rem_sel_reg ? rem_fix : quo_fix;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      rem_reg     <= '0;
      dvd_reg     <= '0;
      dsr_reg     <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      rem_sel_reg <= 1'b0;
      result_reg  <= '0;
      valid_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          valid_reg <= 1'b0;
          if (Start_i) begin
            neg_q_reg   <= sign1 ^ sign2;
            neg_r_reg   <= sign1;
            rem_sel_reg <= Funct_i[1];
            dvd_reg     <= mag1;
            dsr_reg     <= mag2;
            if (div_zero || overflow || early) begin
              result_reg <= special_res;
              valid_reg  <= 1'b1;
              state_reg  <= DONE;
            end else begin
              count_reg <= CW'(WIDTH);
              rem_reg   <= '0;
              state_reg <= CALC;
            end
          end
        end
        CALC: begin
          rem_reg   <= rem_step;
          dvd_reg   <= dvd_step;
          count_reg <= count_reg - 1'b1;
          // Last step: sign fix-up is folded into the result load.
          if (count_reg == CW'(1)) begin
            result_reg <= final_res;
            valid_reg  <= 1'b1;
            state_reg  <= DONE;
          end
        end
        DONE: begin
          valid_reg <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          valid_reg <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign Result_o = result_reg;
  assign Busy_o   = (state_reg != IDLE);
  assign Valid_o  = valid_reg;

endmodule

// File: tb/tb_divider_32bit.sv
// tb_divider_32bit
//   Randomized scoreboard bench for divider_32bit. Stimulus pushes the
//   expected result and latency into a queue; a monitor on the falling edge
//   pops and compares whenever Valid_o is seen.
module tb_divider_32bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  funct = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] result;
  logic        busy;
  logic        valid;

  divider_32bit #(.WIDTH(32)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .Start_i  (start),
    .Funct_i  (funct),
    .rs1_i    (a),
    .rs2_i    (b),
    .Result_o (result),
    .Busy_o   (busy),
    .Valid_o  (valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] res;
    int          st_cyc;
    int          lat;
    string       name;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  bit prev_valid = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
    end
  endtask

  // Reference model from the RV32M rules, using wide signed arithmetic.
  function automatic logic [31:0] ref_div(input logic [1:0] f, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, qq, rr;
    if (y == 32'd0) return f[1] ? x : 32'hFFFF_FFFF;
    if (f[0]) return f[1] ? (x % y) : (x / y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    qq = sx / sy;
    rr = sx % sy;
    return f[1] ? rr[31:0] : qq[31:0];
  endfunction

  function automatic int ref_lat(input logic [1:0] f, input logic [31:0] x, input logic [31:0] y);
    longint mx, my;
    if (y == 32'd0) return 1;
    if (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    mx = f[0] ? longint'(x) : longint'($signed(x));
    my = f[0] ? longint'(y) : longint'($signed(y));
    if (mx < 0) mx = -mx;
    if (my < 0) my = -my;
`ifdef DIV_EARLY_OUT_EN
    if (mx < my) return 1;
`endif
    return 33;
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: got Valid_o=1 expected no pending op (result 0x%08h)", result);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk({e.name, "_result"}, result, e.res);
          chk({e.name, "_latency"}, 32'(cyc - e.st_cyc + 1), 32'(e.lat));
          chk({e.name, "_busy"}, {31'd0, busy}, 32'd1);
          $display("op %s result=0x%08h latency=%0d", e.name, result, cyc - e.st_cyc + 1);
          done_cnt++;
        end
        if (prev_valid) begin
          total++;
          bad++;
          $display("FAIL valid_pulse: got Valid_o high 2 cycles expected 1");
        end
      end
      prev_valid = valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic issue(input string nm, input logic [1:0] f, input logic [31:0] x,
                       input logic [31:0] y, input bit hold);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk); #1;
    while (busy && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL %s_idle_timeout: got Busy_o=1 expected 0", nm);
    end
    funct = f; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    e.res = ref_div(f, x, y);
    e.st_cyc = cyc;
    e.lat = ref_lat(f, x, y);
    e.name = nm;
    q.push_back(e);
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    total++;
    if (done_cnt < target) begin
      bad++;
      $display("FAIL %s_timeout: got %0d completions expected %0d", nm, done_cnt, target);
      q.delete();
    end
  endtask

  task automatic run(input string nm, input logic [1:0] f, input logic [31:0] x, input logic [31:0] y);
    int tgt;
    tgt = done_cnt + 1;
    issue(nm, f, x, y, 1'b0);
    wait_done(nm, tgt);
  endtask

  initial begin
    int tgt;
    logic [1:0]  f;
    logic [31:0] x, y;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_result", result, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    rst_n = 1'b1;

    // Directed cases: DIV=00, DIVU=01, REM=10, REMU=11
    run("div_100_7",      2'b00, 32'd100, 32'd7);
    run("div_m100_7",     2'b00, 32'hFFFF_FF9C, 32'd7);
    run("rem_m100_7",     2'b10, 32'hFFFF_FF9C, 32'd7);
    run("remu_m100_7",    2'b11, 32'hFFFF_FF9C, 32'd7);
    run("divu_by0",       2'b01, 32'h1234_5678, 32'd0);
    run("rem_by0",        2'b10, 32'h1234_5678, 32'd0);
    run("div_ovf",        2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    run("rem_ovf",        2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run("remu_5_9",       2'b11, 32'd5, 32'd9);
    run("div_min_2",      2'b00, 32'h8000_0000, 32'd2);
    run("divu_big",       2'b01, 32'hFFFF_FFFF, 32'h8000_0001);

    // Start held high, operands changed during CALC; Start still high in DONE
    tgt = done_cnt + 1;
    issue("hold_100_7", 2'b00, 32'd100, 32'd7, 1'b1);
    repeat (5) begin
      @(negedge clk); #1;
      a = $urandom; b = $urandom;
    end
    wait_done("hold_100_7", tgt);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    chk("hold_no_restart_busy", {31'd0, busy}, 32'd0);

    // Reset at iteration 10 discards the operation
    issue("rst_abort", 2'b00, 32'd1000, 32'd3, 1'b0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_result", result, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_valid", {31'd0, valid}, 32'd0);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    run("divu_after_rst", 2'b01, 32'hFFFF_FFFF, 32'h10);

    // Randomized mix
    for (int i = 0; i < 40; i++) begin
      f = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'($urandom_range(1, 20));
        1: y = 32'd0;
        2: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        3: begin x = 32'($urandom_range(0, 50)); y = 32'($urandom_range(51, 1000)); end
        4: y = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'hFFFF_FFF9;
        default: ;
      endcase
      run($sformatf("rand%0d", i), f, x, y);
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
